// File: rtl/eeprom_paged.sv
// Paged word memory with a page write buffer, timed programming phase and read-valid strobe.
// Optional write protect (wp / wp_err ports) is enabled by defining EEPROM_WP_EN.
module eeprom_paged #(
  parameter int DW     = 32,
  parameter int AW     = 4,
  parameter int PAGE_W = 2,
  parameter int WR_CYC = 8
) (
  input  logic          c,
  input  logic          rst_n,
  input  logic          str,
  input  logic          ld,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] d_in,
  output logic [DW-1:0] d,
  output logic          d_vld,
  output logic          busy
`ifdef EEPROM_WP_EN
  ,
  input  logic          wp,
  output logic          wp_err
`endif
);

  localparam int DEPTH = 1 << AW;
  localparam int PAGE  = 1 << PAGE_W;
  localparam int IW    = (PAGE_W > 0) ? PAGE_W : 1;
  localparam int CW    = (WR_CYC > 1) ? $clog2(WR_CYC) : 1;
  localparam logic [AW-1:0] LOW_MASK = AW'(PAGE - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PROG} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PAGE-1:0] mask_q, mask_d;
  logic [DW-1:0] buf_q [PAGE];
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] d_q;
  logic          vld_q, vld_d;
  logic          buf_we;
  logic          rd_en;
  logic          commit;
  logic          wr_block;
  logic          wp_hit;
  logic [IW-1:0] idx;

`ifdef EEPROM_WP_EN
  assign wr_block = wp;
`else
  assign wr_block = 1'b0;
`endif

  // Index within the page; page bits of a are ignored while a page is being loaded.
  assign idx    = IW'(a & LOW_MASK);
  assign commit = (state_q == PROG) && (cnt_q == '0);
  assign rd_en  = ld && (state_q != PROG);
  assign wp_hit = (state_q == IDLE) && str && wr_block;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    buf_we  = 1'b0;
    vld_d   = rd_en;
    case (state_q)
      IDLE: begin
        if (str && !wr_block) begin
          base_d      = a & ~LOW_MASK;
          buf_we      = 1'b1;
          mask_d[idx] = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (str) begin
          buf_we      = 1'b1;
          mask_d[idx] = 1'b1;
        end else begin
          cnt_d   = CW'(WR_CYC - 1);
          state_d = PROG;
        end
      end
      PROG: begin
        if (cnt_q == '0) begin
          mask_d  = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge c) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      vld_q   <= 1'b0;
      for (int i = 0; i < PAGE; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      vld_q   <= vld_d;
      if (buf_we) buf_q[idx] <= d_in;
    end
  end

  // Array is never reset; reset on the commit cycle suppresses the commit.
  always_ff @(posedge c) begin
    if (rst_n && commit) begin
      for (int i = 0; i < PAGE; i++) begin
        if (mask_q[i]) mem[base_q | AW'(i)] <= buf_q[i];
      end
    end
  end

  always_ff @(posedge c) begin
    if (!rst_n) d_q <= '0;
    else if (rd_en) d_q <= mem[a];
  end

`ifdef EEPROM_WP_EN
  logic wp_err_q;
  always_ff @(posedge c) begin
    if (!rst_n) wp_err_q <= 1'b0;
    else wp_err_q <= wp_hit;
  end
  assign wp_err = wp_err_q;
`else
  logic unused_wp;
  assign unused_wp = wp_hit;
`endif

  assign d     = d_q;
  assign d_vld = vld_q;
  assign busy  = (state_q == PROG);

endmodule

// File: tb/tb_eeprom_paged.sv
// Randomised + directed bench for eeprom_paged against a page-buffer reference model.
// Define EEPROM_WP_EN to also exercise the write-protect ports.
module tb_eeprom_paged;

  logic        c;
  logic        rst_n;
  logic        str;
  logic        ld;
  logic [3:0]  a;
  logic [31:0] d_in;
  logic [31:0] d;
  logic        d_vld;
  logic        busy;
`ifdef EEPROM_WP_EN
  logic        wp;
  logic        wp_err;
`endif

  int errors = 0;
  int checks = 0;

  eeprom_paged #(.DW(32), .AW(4), .PAGE_W(2), .WR_CYC(8)) dut (
    .c(c), .rst_n(rst_n), .str(str), .ld(ld), .a(a), .d_in(d_in),
    .d(d), .d_vld(d_vld), .busy(busy)
`ifdef EEPROM_WP_EN
    , .wp(wp), .wp_err(wp_err)
`endif
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference model: committed array, pending page words, and a programming countdown.
  logic [31:0] mem_m [16];
  logic [31:0] pend_v [4];
  bit          pend_ok [4];
  int          page_m;
  int          mode;
  int          left;
  logic [31:0] exp_d;
  bit          exp_vld, exp_busy, exp_wperr, known;
  bit          blk;

  initial begin
    known = 0; mode = 0; exp_d = 0; exp_vld = 0; exp_busy = 0; exp_wperr = 0;
    for (int i = 0; i < 16; i++) mem_m[i] = 0;
  end

  always @(posedge c) begin
`ifdef EEPROM_WP_EN
    blk = wp;
`else
    blk = 0;
`endif
    if (!rst_n) begin
      exp_d = 0; exp_vld = 0; exp_wperr = 0; mode = 0; known = 1;
      for (int i = 0; i < 4; i++) pend_ok[i] = 0;
    end else begin
      exp_vld = 0;
      exp_wperr = 0;
      if (mode != 2 && ld) begin
        exp_d = mem_m[a];
        exp_vld = 1;
      end
      if (mode == 0) begin
        if (str && blk) exp_wperr = 1;
        else if (str) begin
          page_m = int'(a) / 4;
          pend_v[int'(a) % 4] = d_in;
          pend_ok[int'(a) % 4] = 1;
          mode = 1;
        end
      end else if (mode == 1) begin
        if (str) begin
          pend_v[int'(a) % 4] = d_in;
          pend_ok[int'(a) % 4] = 1;
        end else begin
          mode = 2;
          left = 8;
        end
      end else begin
        left--;
        if (left == 0) begin
          for (int i = 0; i < 4; i++) begin
            if (pend_ok[i]) mem_m[page_m * 4 + i] = pend_v[i];
            pend_ok[i] = 0;
          end
          mode = 0;
        end
      end
    end
    exp_busy = (mode == 2);
    #1;
    if (known) begin
      chk("d", d, exp_d);
      chk("d_vld", {31'b0, d_vld}, {31'b0, exp_vld});
      chk("busy", {31'b0, busy}, {31'b0, exp_busy});
`ifdef EEPROM_WP_EN
      chk("wp_err", {31'b0, wp_err}, {31'b0, exp_wperr});
`endif
    end
  end

  task automatic cyc(input bit r, input bit s, input bit l, input int ad, input logic [31:0] dv);
    @(negedge c);
    rst_n = r; str = s; ld = l; a = ad[3:0]; d_in = dv;
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      idle();
      if (!busy) break;
    end
    chk("wait_idle", {31'b0, busy}, 32'd0);
  endtask

  task automatic read_lit(input int ad, input logic [31:0] exp);
    cyc(1, 0, 1, ad, 0);
    idle();
    chk("rd_lit_d", d, exp);
    chk("rd_lit_vld", {31'b0, d_vld}, 32'd1);
  endtask

  initial begin
    int bc;
    rst_n = 0; str = 0; ld = 0; a = 0; d_in = 0;
`ifdef EEPROM_WP_EN
    wp = 0;
`endif
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    idle();
    chk("rst_d", d, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);

    // Test 1: one page, busy length, read back
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, i, i + 1);
    idle();
    bc = 0;
    for (int k = 0; k < 40; k++) begin
      idle();
      if (busy) bc++;
    end
    chk("busy_len", bc, 32'd8);
    for (int i = 0; i < 4; i++) read_lit(i, i + 1);

    // Test 2: fill all pages, then streaming read sweep
    for (int p = 0; p < 4; p++) begin
      for (int j = 0; j < 4; j++) cyc(1, 1, 0, p * 4 + j, p * 4 + j + 1);
      idle();
      wait_idle();
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 1, i, 0);
      if (i > 0) chk("sweep", d, i);
    end
    idle();
    chk("sweep_last", d, 32'd16);

    // Test 3: same-cycle store and load reads the old word
    cyc(1, 1, 1, 5, 32'hAA);
    idle();
    chk("rbw_old", d, 32'd6);
    wait_idle();
    read_lit(5, 32'hAA);

    // Test 4: page wrap, a=6 lands on index 2 of the latched page
    cyc(1, 1, 0, 2, 32'h11);
    cyc(1, 1, 0, 6, 32'h22);
    idle();
    wait_idle();
    read_lit(2, 32'h22);
    read_lit(6, 32'd7);
    read_lit(0, 32'd1);
    read_lit(1, 32'd2);
    read_lit(3, 32'd4);

    // Test 5: reset during PROG aborts the commit
    cyc(1, 1, 0, 8, 32'h55);
    idle();
    idle(); idle(); idle();
    cyc(0, 0, 0, 0, 0);
    idle();
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_vld", {31'b0, d_vld}, 32'd0);
    chk("abort_d", d, 32'd0);
    wait_idle();
    read_lit(8, 32'd9);

`ifdef EEPROM_WP_EN
    // Test 6: write protect blocks the store
    wp = 1;
    cyc(1, 1, 0, 1, 32'hFF);
    idle();
    chk("wp_err_pulse", {31'b0, wp_err}, 32'd1);
    chk("wp_busy", {31'b0, busy}, 32'd0);
    idle();
    chk("wp_err_end", {31'b0, wp_err}, 32'd0);
    read_lit(1, 32'd2);
    wp = 0;
    cyc(1, 1, 0, 1, 32'hFF);
    idle();
    wait_idle();
    read_lit(1, 32'hFF);
`endif

    // Randomised traffic checked cycle by cycle against the model
    for (int k = 0; k < 1500; k++) begin
`ifdef EEPROM_WP_EN
      wp = ($urandom_range(0, 7) == 0);
`endif
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
          $urandom_range(0, 15), $urandom);
    end
    idle();
    wait_idle();
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 1, i, 0);
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
